stream_demux_1_4: RTL and testbench

- Single valid/ready stream in, four valid/ready streams out. The complement of the team's 4:1 selection muxes: routes each accepted input word to one of four output channels.
- Destination comes from an explicit per-word select or from an internal round-robin pointer.
- Each output channel has a one-entry register slice, so outputs are registered and a stalled channel does not corrupt the others.
- Sits between a single producer and four consumer lanes.

---
 rtl/stream_demux_1_4_pkg.sv | 14 +
 rtl/stream_slot.sv | 47 ++++
 rtl/stream_demux_1_4.sv | 71 +++++++
 tb/tb_stream_demux_1_4.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_1_4_pkg.sv
// rtl/stream_demux_1_4_pkg.sv - shared constants and types for the 1:4 stream demux
package stream_demux_1_4_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    // Round-robin successor, wrapping 3 -> 0.
    function automatic sel_t next_sel(input sel_t cur);
        return cur + sel_t'(1);
    endfunction

endpackage

// File: rtl/stream_slot.sv
// rtl/stream_slot.sv - one-entry register slice feeding a single output channel
module stream_slot #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic         full,
    output logic [W-1:0] data,
    output logic         can_accept
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;

    // The slot can take a word when empty or when its held word leaves this cycle.
    assign can_accept = ~full_q | out_ready;

    // Load wins over drain so a streaming channel stays full; data only moves on load.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (load) begin
            full_d = 1'b1;
            data_d = load_data;
        end else if (full_q && out_ready) begin
            full_d = 1'b0;
        end
    end

    // Slot state register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign data = data_q;

endmodule

// File: rtl/stream_demux_1_4.sv
// rtl/stream_demux_1_4.sv - routes one valid/ready stream to four registered output channels
module stream_demux_1_4
    import stream_demux_1_4_pkg::*;
#(
    parameter int W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [W-1:0]      up_data,
    input  logic [1:0]        up_sel,
    input  logic              rr_mode,
    output logic [N_CH-1:0]   down_valid,
    input  logic [N_CH-1:0]   down_ready,
    output logic [N_CH*W-1:0] down_data,
    output logic [1:0]        rr_ptr
);

    sel_t            rr_ptr_q, rr_ptr_d;
    sel_t            dest;
    logic            accept;
    logic [N_CH-1:0] load;
    logic [N_CH-1:0] can_accept;

    // Destination is the round-robin pointer or the per-word select.
    assign dest     = rr_mode ? rr_ptr_q : up_sel;
    assign up_ready = ~rst & can_accept[dest];
    assign accept   = up_valid & up_ready;

    // One-hot load to the addressed slot; other slots are left alone.
    always_comb begin
        load = '0;
        if (accept) begin
            load[dest] = 1'b1;
        end
    end

    // Pointer advances only on words actually accepted in round-robin mode.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept && rr_mode) begin
            rr_ptr_d = next_sel(rr_ptr_q);
        end
    end

    // Round-robin pointer register; survives rr_mode toggles, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rr_ptr = rr_ptr_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_slot
        stream_slot #(.W(W)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .load       (load[k]),
            .load_data  (up_data),
            .out_ready  (down_ready[k]),
            .full       (down_valid[k]),
            .data       (down_data[k*W +: W]),
            .can_accept (can_accept[k])
        );
    end

endmodule

// File: tb/tb_stream_demux_1_4.sv
// tb/tb_stream_demux_1_4.sv - self-checking bench for stream_demux_1_4
module tb_stream_demux_1_4;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         up_valid;
    logic         up_ready;
    logic [W-1:0] up_data;
    logic [1:0]   up_sel;
    logic         rr_mode;
    logic [3:0]   down_valid;
    logic [3:0]   down_ready;
    logic [4*W-1:0] down_data;
    logic [1:0]   rr_ptr;

    int errors = 0;
    int checks = 0;
    bit done   = 1'b0;

    // Reference state: what each channel holds and where round-robin points.
    bit       full_m [4];
    bit [3:0] data_m [4];
    int       rr_m;

    stream_demux_1_4 #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_sel     (up_sel),
        .rr_mode    (rr_mode),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data),
        .rr_ptr     (rr_ptr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_dest();
        return rr_mode ? rr_m : int'(up_sel);
    endfunction

    function automatic int model_ready();
        int d;
        d = model_dest();
        if (rst) return 0;
        return (!full_m[d] || down_ready[d]) ? 1 : 0;
    endfunction

    initial begin
        for (int k = 0; k < 4; k++) begin
            full_m[k] = 1'b0;
            data_m[k] = '0;
        end
        rr_m = 0;
    end

    // Model update: apply the spec's accept/drain/pointer rules at each edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                full_m[k] = 1'b0;
                data_m[k] = '0;
            end
            rr_m = 0;
        end else begin
            int d;
            bit acc;
            d   = model_dest();
            acc = up_valid && (model_ready() == 1);
            for (int k = 0; k < 4; k++)
                if (full_m[k] && down_ready[k]) full_m[k] = 1'b0;
            if (acc) begin
                full_m[d] = 1'b1;
                data_m[d] = up_data;
                if (rr_mode) rr_m = (rr_m + 1) % 4;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!done) begin
            check("up_ready", int'(up_ready), model_ready());
            check("rr_ptr", int'(rr_ptr), rr_m);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("down_valid[%0d]", k), int'(down_valid[k]), int'(full_m[k]));
                check($sformatf("down_data[%0d]", k), int'(down_data[k*W +: W]), int'(data_m[k]));
            end
        end
    end

    task automatic drive(input bit v, input int sel, input int d, input bit rr, input bit [3:0] dr);
        up_valid   = v;
        up_sel     = 2'(sel);
        up_data    = 4'(d);
        rr_mode    = rr;
        down_ready = dr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int ch(input int k);
        return int'(down_data[k*W +: W]);
    endfunction

    initial begin
        rst = 1'b1;
        drive(1'b1, 0, 4'h3, 1'b0, 4'hF);
        // Reset: two cycles with input offered.
        step();
        step();
        check("rst up_ready", int'(up_ready), 0);
        check("rst down_valid", int'(down_valid), 0);
        check("rst rr_ptr", int'(rr_ptr), 0);
        rst = 1'b0;
        drive(1'b0, 0, 0, 1'b0, 4'hF);
        step();
        step();
        check("idle down_valid", int'(down_valid), 0);
        check("idle down_data", int'(down_data), 0);

        // Select routing: A->2, B->0, C->3, D->1.
        drive(1'b1, 2, 4'hA, 1'b0, 4'hF);
        check("route up_ready", int'(up_ready), 1);
        step();
        check("route A valid", int'(down_valid), 4'b0100);
        check("route A data", ch(2), 4'hA);
        drive(1'b1, 0, 4'hB, 1'b0, 4'hF);
        step();
        check("route B valid", int'(down_valid), 4'b0001);
        check("route B data", ch(0), 4'hB);
        drive(1'b1, 3, 4'hC, 1'b0, 4'hF);
        step();
        check("route C valid", int'(down_valid), 4'b1000);
        check("route C data", ch(3), 4'hC);
        drive(1'b1, 1, 4'hD, 1'b0, 4'hF);
        step();
        check("route D valid", int'(down_valid), 4'b0010);
        check("route D data", ch(1), 4'hD);
        drive(1'b0, 0, 0, 1'b0, 4'hF);
        step();

        // Backpressure isolation on channel 1.
        drive(1'b1, 1, 5, 1'b0, 4'b1101);
        step();
        check("bp 5 valid1", int'(down_valid[1]), 1);
        check("bp 5 data1", ch(1), 5);
        drive(1'b1, 1, 6, 1'b0, 4'b1101);
        #1;
        check("bp 6 blocked", int'(up_ready), 0);
        step();
        check("bp hold data1", ch(1), 5);
        drive(1'b1, 3, 7, 1'b0, 4'b1101);
        #1;
        check("bp 7 ready", int'(up_ready), 1);
        step();
        check("bp 7 data3", ch(3), 7);
        check("bp still 5", ch(1), 5);
        drive(1'b1, 1, 6, 1'b0, 4'b1111);
        #1;
        check("bp 6 ready", int'(up_ready), 1);
        step();
        check("bp 6 loaded", ch(1), 6);
        check("bp 6 valid", int'(down_valid), 4'b0010);
        drive(1'b0, 0, 0, 1'b0, 4'hF);
        step();

        // Round-robin wrap: 10..15 -> 0,1,2,3,0,1.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 3, 10 + i, 1'b1, 4'hF);
            step();
            check("rr chan valid", int'(down_valid), 1 << (i % 4));
            check("rr chan data", ch(i % 4), 10 + i);
        end
        check("rr end ptr", int'(rr_ptr), 2);

        // Bring pointer to 1: words to ch2, ch3, ch0.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 0, i, 1'b1, 4'hF);
            step();
        end
        check("rr ptr at 1", int'(rr_ptr), 1);
        // Fill ch1 by select while stalled, then stall round-robin on it.
        drive(1'b1, 1, 8, 1'b0, 4'b1101);
        step();
        drive(1'b1, 0, 9, 1'b1, 4'b1101);
        #1;
        check("rr stall ready", int'(up_ready), 0);
        step();
        check("rr stall ptr", int'(rr_ptr), 1);
        check("rr stall hold", ch(1), 8);
        drive(1'b1, 0, 9, 1'b1, 4'b1111);
        #1;
        check("rr unstall ready", int'(up_ready), 1);
        step();
        check("rr unstall ptr", int'(rr_ptr), 2);
        check("rr unstall data", ch(1), 9);

        // Mid-operation reset with ch0/ch2 held and rr_ptr=3.
        drive(1'b1, 0, 4, 1'b1, 4'b0010);
        step();
        drive(1'b1, 0, 3, 1'b0, 4'b0010);
        step();
        check("pre-rst valid", int'(down_valid), 4'b0101);
        check("pre-rst ptr", int'(rr_ptr), 3);
        drive(1'b0, 0, 0, 1'b0, 4'b0000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid-rst valid", int'(down_valid), 0);
        check("mid-rst data", int'(down_data), 0);
        check("mid-rst ptr", int'(rr_ptr), 0);
        drive(1'b1, 2, 4'hE, 1'b1, 4'hF);
        step();
        check("post-rst valid", int'(down_valid), 4'b0001);
        check("post-rst data", ch(0), 4'hE);
        drive(1'b0, 0, 0, 1'b0, 4'hF);
        step();
        step();

        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
